rcl_sched: RTL and testbench

RCL_SCHED -- requirements
Module: rcl_sched

---
 rtl/rcl_sched_pkg.sv | 15 +
 rtl/rcl_req_buf.sv | 41 ++++
 rtl/rcl_sched.sv | 138 +++++++++++++
 tb/tb_rcl_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcl_sched_pkg.sv
// rcl_sched_pkg: shared scheduler states, relation codes and packet geometry
package rcl_sched_pkg;

    typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT, RESP} state_t;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_TANGENT = 2'd1;
    localparam logic [1:0] RES_SECANT  = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

    localparam int BEATS = 3;

    typedef logic [BEATS-1:0][4:0] pkt_t;

endpackage

// File: rtl/rcl_req_buf.sv
// rcl_req_buf: per-port 3-beat packet capture with full flag and busy indication
module rcl_req_buf
    import rcl_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] coef_q,
    input  logic [4:0] coef_l,
    input  logic       clr,
    output logic       full,
    output logic       busy,
    output pkt_t       q,
    output pkt_t       l
);

    logic [1:0] idx;
    logic       take;
    logic       last_beat;

    // A full buffer refuses new beats until the scheduler returns its result
    assign take      = in_valid && !full;
    assign last_beat = idx == 2'(BEATS - 1);
    assign busy      = full || idx != 2'd0;

    // Capture beats in order; the final beat marks the packet ready
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx  <= 2'd0;
            full <= 1'b0;
            q    <= '0;
            l    <= '0;
        end else if (take) begin
            q[idx] <= coef_q;
            l[idx] <= coef_l;
            idx    <= last_beat ? 2'd0 : idx + 2'd1;
            full   <= last_beat;
        end
    end

endmodule

// File: rtl/rcl_sched.sv
// rcl_sched: two-port round-robin scheduler feeding a shared relation engine (optional WAIT timeout via RCL_SCHED_TIMEOUT_EN)
module rcl_sched
    import rcl_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_0,
    input  logic       in_valid_1,
    input  logic [4:0] coef_Q_0,
    input  logic [4:0] coef_Q_1,
    input  logic [4:0] coef_L_0,
    input  logic [4:0] coef_L_1,
    output logic       busy_0,
    output logic       busy_1,
    output logic       out_valid_0,
    output logic       out_valid_1,
    output logic [1:0] out_0,
    output logic [1:0] out_1,
    output logic       timeout_err,
    output logic       eng_in_valid,
    output logic [4:0] eng_coef_Q,
    output logic [4:0] eng_coef_L,
    input  logic       eng_out_valid,
    input  logic [1:0] eng_out
);

    state_t     state, nstate;
    logic       gnt, ngnt, last, tout, send, resp0, resp1;
    logic [1:0] nres, bidx, full, clr;
    logic [4:0] sel_q, sel_l;
    pkt_t       q0, l0, q1, l1;

    rcl_req_buf u_buf0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid_0),
        .coef_q   (coef_Q_0),
        .coef_l   (coef_L_0),
        .clr      (clr[0]),
        .full     (full[0]),
        .busy     (busy_0),
        .q        (q0),
        .l        (l0)
    );

    rcl_req_buf u_buf1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid_1),
        .coef_q   (coef_Q_1),
        .coef_l   (coef_L_1),
        .clr      (clr[1]),
        .full     (full[1]),
        .busy     (busy_1),
        .q        (q1),
        .l        (l1)
    );

`ifdef RCL_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    // Count cycles spent in WAIT; restarts on every entry
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

    assign tout = state == WAIT && !eng_out_valid && cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign tout = TIMEOUT_CYC < 0;
`endif

    assign clr[0] = state == RESP && !gnt;
    assign clr[1] = state == RESP && gnt;
    assign send   = nstate inside {SEND0, SEND1, SEND2};
    assign bidx   = nstate == SEND1 ? 2'd1 : nstate == SEND2 ? 2'd2 : 2'd0;
    assign sel_q  = ngnt ? q1[bidx] : q0[bidx];
    assign sel_l  = ngnt ? l1[bidx] : l0[bidx];
    assign resp0  = nstate == RESP && !ngnt;
    assign resp1  = nstate == RESP && ngnt;

    // Next state, grant choice and the result code carried into RESP
    always_comb begin
        nstate = state;
        ngnt   = gnt;
        nres   = RES_NONE;
        case (state)
            IDLE: if (|full) begin
                nstate = SEND0;
                ngnt   = &full ? !last : full[1];
            end
            SEND0: nstate = SEND1;
            SEND1: nstate = SEND2;
            SEND2: nstate = WAIT;
            WAIT: if (eng_out_valid) begin
                nstate = RESP;
                nres   = eng_out;
            end else if (tout) begin
                nstate = RESP;
                nres   = RES_TIMEOUT;
            end
            default: nstate = IDLE;
        endcase
    end

    // State, round-robin pointer and all outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            last         <= 1'b1;
            eng_in_valid <= 1'b0;
            eng_coef_Q   <= '0;
            eng_coef_L   <= '0;
            out_valid_0  <= 1'b0;
            out_valid_1  <= 1'b0;
            out_0        <= RES_NONE;
            out_1        <= RES_NONE;
            timeout_err  <= 1'b0;
        end else begin
            state        <= nstate;
            gnt          <= ngnt;
            last         <= state == IDLE && |full ? ngnt : last;
            eng_in_valid <= nstate == SEND0;
            eng_coef_Q   <= send ? sel_q : 5'd0;
            eng_coef_L   <= send ? sel_l : 5'd0;
            out_valid_0  <= resp0;
            out_valid_1  <= resp1;
            out_0        <= resp0 ? nres : RES_NONE;
            out_1        <= resp1 ? nres : RES_NONE;
            timeout_err  <= nstate == RESP && tout;
        end
    end

endmodule

// File: tb/tb_rcl_sched.sv
// tb_rcl_sched: directed self-checking bench for rcl_sched with a behavioural relation engine
module tb_rcl_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_0 = 1'b0, in_valid_1 = 1'b0;
    logic [4:0] coef_Q_0 = '0, coef_Q_1 = '0, coef_L_0 = '0, coef_L_1 = '0;
    logic       busy_0, busy_1, out_valid_0, out_valid_1, timeout_err;
    logic [1:0] out_0, out_1;
    logic       eng_in_valid;
    logic [4:0] eng_coef_Q, eng_coef_L;
    logic       eng_out_valid;
    logic [1:0] eng_out;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int ov_n = 0, iv_n = 0, to_n = 0, zviol = 0;
    int order[$];
    logic [1:0] last0 = '0, last1 = '0;
    logic [4:0] pq0[3], pl0[3], pq1[3], pl1[3];
    logic [4:0] eq[3], el[3];
    bit eng_on = 1'b1;
    int eng_lat = 1;

    rcl_sched dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_0    (in_valid_0),
        .in_valid_1    (in_valid_1),
        .coef_Q_0      (coef_Q_0),
        .coef_Q_1      (coef_Q_1),
        .coef_L_0      (coef_L_0),
        .coef_L_1      (coef_L_1),
        .busy_0        (busy_0),
        .busy_1        (busy_1),
        .out_valid_0   (out_valid_0),
        .out_valid_1   (out_valid_1),
        .out_0         (out_0),
        .out_1         (out_1),
        .timeout_err   (timeout_err),
        .eng_in_valid  (eng_in_valid),
        .eng_coef_Q    (eng_coef_Q),
        .eng_coef_L    (eng_coef_L),
        .eng_out_valid (eng_out_valid),
        .eng_out       (eng_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor: records pulses, grant order and out_i idle violations
    always @(negedge clk) begin
        if (out_valid_0) begin ov_n++; last0 = out_0; order.push_back(0); end
        else if (out_0 !== 2'd0) zviol++;
        if (out_valid_1) begin ov_n++; last1 = out_1; order.push_back(1); end
        else if (out_1 !== 2'd0) zviol++;
        if (timeout_err) to_n++;
        if (eng_in_valid) iv_n++;
    end

    // Engine model: collect three beats, then answer after eng_lat WAIT cycles
    initial begin
        int m, n, k, a, b, c, d, r;
        eng_out_valid = 1'b0;
        eng_out = 2'd0;
        forever begin
            @(negedge clk);
            eng_out_valid = 1'b0;
            eng_out = 2'd0;
            if (eng_on && eng_in_valid === 1'b1) begin
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    eq[i] = eng_coef_Q;
                    el[i] = eng_coef_L;
                end
                repeat (eng_lat) @(negedge clk);
                m = int'($signed(eq[0])); n = int'($signed(eq[1])); k = int'($signed(eq[2]));
                a = int'($signed(el[0])); b = int'($signed(el[1])); c = int'($signed(el[2]));
                d = a * m + b * n + c;
                r = k * (a * a + b * b);
                eng_out_valid = 1'b1;
                eng_out = d * d > r ? 2'd0 : d * d == r ? 2'd1 : 2'd2;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic [4:0] m, a, n, b, k, c);
        pq0 = '{m, n, k};
        pl0 = '{a, b, c};
    endtask

    task automatic set1(input logic [4:0] m, a, n, b, k, c);
        pq1 = '{m, n, k};
        pl1 = '{a, b, c};
    endtask

    task automatic send(input logic [1:0] pm);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_0 = pm[0];
            in_valid_1 = pm[1];
            coef_Q_0 = pq0[i]; coef_L_0 = pl0[i];
            coef_Q_1 = pq1[i]; coef_L_1 = pl1[i];
        end
        @(negedge clk);
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
    endtask

    task automatic wait_ov(input string tag, input int target);
        int t = 0;
        while (ov_n < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, ov_n >= target, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int b, s;
        repeat (2) @(negedge clk);
        chk("rst_busy_0", busy_0, 0);
        chk("rst_busy_1", busy_1, 0);
        chk("rst_ov0", out_valid_0, 0);
        chk("rst_ov1", out_valid_1, 0);
        chk("rst_out0", out_0, 0);
        chk("rst_out1", out_1, 0);
        chk("rst_eiv", eng_in_valid, 0);
        chk("rst_eq", eng_coef_Q, 0);
        chk("rst_el", eng_coef_L, 0);
        chk("rst_to", timeout_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous pair right after reset: port0 then port1
        set0(5'd3, 5'd1, 5'd0, 5'd0, 5'd4, 5'd0);
        set1(5'd0, 5'd1, 5'd0, 5'd0, 5'd4, 5'h1E);
        b = order.size();
        send(2'b11);
        chk("pairA_busy1", busy_1, 1);
        wait_ov("pairA_done", 2);
        chk("pairA_first", order[b], 0);
        chk("pairA_second", order[b+1], 1);
        chk("pairA_out0", last0, 0);
        chk("pairA_out1", last1, 1);

        // Single port0 packet with exact engine-side timing
        set0(5'd3, 5'd1, 5'd0, 5'd0, 5'd4, 5'd0);
        s = iv_n;
        send(2'b01);
        chk("p0_busy_full", busy_0, 1);
        chk("p0_eiv_T", eng_in_valid, 0);
        @(negedge clk);
        chk("p0_eiv_s0", eng_in_valid, 1);
        chk("p0_q_s0", eng_coef_Q, 3);
        chk("p0_l_s0", eng_coef_L, 1);
        @(negedge clk);
        chk("p0_eiv_s1", eng_in_valid, 0);
        chk("p0_q_s1", eng_coef_Q, 0);
        chk("p0_l_s1", eng_coef_L, 0);
        @(negedge clk);
        chk("p0_q_s2", eng_coef_Q, 4);
        chk("p0_l_s2", eng_coef_L, 0);
        @(negedge clk);
        chk("p0_q_wait", eng_coef_Q, 0);
        chk("p0_ov_wait", out_valid_0, 0);
        @(negedge clk);
        chk("p0_ov", out_valid_0, 1);
        chk("p0_out", out_0, 0);
        chk("p0_busy_resp", busy_0, 1);
        @(negedge clk);
        chk("p0_ov_after", out_valid_0, 0);
        chk("p0_busy_after", busy_0, 0);
        chk("p0_iv_count", iv_n - s, 1);
        repeat (2) @(negedge clk);

        // Second pair after port0 was granted last: port1 wins
        set0(5'd0, 5'd1, 5'd0, 5'd0, 5'd4, 5'h1E);
        set1(5'd3, 5'd1, 5'd0, 5'd0, 5'd4, 5'd0);
        b = order.size();
        send(2'b11);
        wait_ov("pairB_done", ov_n + 2);
        chk("pairB_first", order[b], 1);
        chk("pairB_second", order[b+1], 0);
        chk("pairB_out1", last1, 0);
        chk("pairB_out0", last0, 1);

        // Port1 tangent then secant
        set1(5'd0, 5'd1, 5'd0, 5'd0, 5'd4, 5'h1E);
        send(2'b10);
        wait_ov("p1_tan_done", ov_n + 1);
        chk("p1_tangent", last1, 1);
        set1(5'd0, 5'd1, 5'd0, 5'd0, 5'd9, 5'h1E);
        send(2'b10);
        wait_ov("p1_sec_done", ov_n + 1);
        chk("p1_secant", last1, 2);

        // Strobes while port0 is busy must not disturb the held packet
        eng_lat = 4;
        set0(5'd0, 5'd1, 5'd0, 5'd0, 5'd9, 5'h1E);
        b = ov_n;
        send(2'b01);
        in_valid_0 = 1'b1; coef_Q_0 = 5'h0F; coef_L_0 = 5'h0F;
        @(negedge clk);
        chk("ign_busy", busy_0, 1);
        @(negedge clk);
        in_valid_0 = 1'b0;
        wait_ov("ign_done", b + 1);
        chk("ign_out", last0, 2);
        chk("ign_eng_k", eq[2], 9);
        chk("ign_eng_c", el[2], 5'h1E);
        repeat (6) @(negedge clk);
        chk("ign_single", ov_n, b + 1);
        chk("ign_busy_end", busy_0, 0);
        eng_lat = 1;

        // Reset while waiting on the engine discards the transaction
        eng_on = 1'b0;
        set1(5'd0, 5'd1, 5'd0, 5'd0, 5'd4, 5'h1E);
        b = ov_n;
        send(2'b10);
        repeat (5) @(negedge clk);
        chk("rstw_busy_pre", busy_1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_busy", busy_1, 0);
        chk("rstw_ov", out_valid_1, 0);
        chk("rstw_eiv", eng_in_valid, 0);
        repeat (20) @(negedge clk);
        chk("rstw_no_result", ov_n, b);
        eng_on = 1'b1;
        set1(5'd0, 5'd1, 5'd0, 5'd0, 5'd9, 5'h1E);
        send(2'b10);
        wait_ov("rstw_new_done", b + 1);
        chk("rstw_new_out", last1, 2);

`ifdef RCL_SCHED_TIMEOUT_EN
        // Silent engine: RESP 18 cycles after SEND0 (3 send beats + 15 WAIT cycles)
        eng_on = 1'b0;
        set0(5'd3, 5'd1, 5'd0, 5'd0, 5'd4, 5'd0);
        send(2'b01);
        s = 0;
        while (eng_in_valid !== 1'b1 && s < 10) begin @(negedge clk); s++; end
        chk("to_start", eng_in_valid, 1);
        b = cyc;
        s = 0;
        while (out_valid_0 !== 1'b1 && s < 100) begin @(negedge clk); s++; end
        chk("to_latency", cyc - b, 18);
        chk("to_out", out_0, 3);
        chk("to_err", timeout_err, 1);
        @(negedge clk);
        chk("to_err_pulse", timeout_err, 0);
        eng_on = 1'b1;
`else
        chk("no_timeout_err", to_n, 0);
`endif

        chk("out_zero_when_idle", zviol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
